mem_arbiter: RTL and testbench

// - Shares one single-outstanding memory port between IFU (m0) and LSU (m1).
// - Both sides use valid/ready; one transaction = request handshake, then response handshake.
// - Sits between the fetch/load-store stage handshakes and the memory/bus bridge.
// - Serialises traffic: one transaction in flight, grant held until its response is consumed.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master, single-outstanding memory port arbiter (IFU = m0, LSU = m1).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise m1 wins every tie.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   // master 0 (IFU)
   input  logic                m0_req_valid,
   output logic                m0_req_ready,
   input  logic [ADDR_W-1:0]   m0_req_addr,
   input  logic                m0_req_wen,
   input  logic [DATA_W-1:0]   m0_req_wdata,
   input  logic [DATA_W/8-1:0] m0_req_wmask,
   output logic                m0_rsp_valid,
   input  logic                m0_rsp_ready,
   output logic [DATA_W-1:0]   m0_rsp_rdata,
   // master 1 (LSU)
   input  logic                m1_req_valid,
   output logic                m1_req_ready,
   input  logic [ADDR_W-1:0]   m1_req_addr,
   input  logic                m1_req_wen,
   input  logic [DATA_W-1:0]   m1_req_wdata,
   input  logic [DATA_W/8-1:0] m1_req_wmask,
   output logic                m1_rsp_valid,
   input  logic                m1_rsp_ready,
   output logic [DATA_W-1:0]   m1_rsp_rdata,
   // downstream memory port
   output logic                s_req_valid,
   input  logic                s_req_ready,
   output logic [ADDR_W-1:0]   s_req_addr,
   output logic                s_req_wen,
   output logic [DATA_W-1:0]   s_req_wdata,
   output logic [DATA_W/8-1:0] s_req_wmask,
   input  logic                s_rsp_valid,
   output logic                s_rsp_ready,
   input  logic [DATA_W-1:0]   s_rsp_rdata,
   // status
   output logic                busy,
   output logic                grant
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0] r_state;
   logic       r_grant;
   logic       w_any_req;
   logic       w_winner;
   logic       w_in_req;
   logic       w_in_resp;
   logic       w_req_fire;
   logic       w_rsp_fire;

   assign w_any_req = m0_req_valid | m1_req_valid;
   assign w_in_req  = (r_state == REQ);
   assign w_in_resp = (r_state == RESP);

`ifdef MEM_ARB_RR_EN
   logic r_last;
   // On a tie, the master that did not finish last gets the port.
   always_comb begin
      w_winner = 1'b0;
      if (m0_req_valid && m1_req_valid) w_winner = ~r_last;
      else                              w_winner = m1_req_valid;
   end
`else
   assign w_winner = m1_req_valid;
`endif

   // Downstream request: granted master's payload, valid only while in REQ.
   assign s_req_valid  = w_in_req & (r_grant ? m1_req_valid : m0_req_valid);
   assign s_req_addr   = r_grant ? m1_req_addr  : m0_req_addr;
   assign s_req_wen    = r_grant ? m1_req_wen   : m0_req_wen;
   assign s_req_wdata  = r_grant ? m1_req_wdata : m0_req_wdata;
   assign s_req_wmask  = r_grant ? m1_req_wmask : m0_req_wmask;
   assign m0_req_ready = w_in_req & ~r_grant & s_req_ready;
   assign m1_req_ready = w_in_req &  r_grant & s_req_ready;

   // Response path is purely combinational; stray responses outside RESP are dropped.
   assign s_rsp_ready  = w_in_resp & (r_grant ? m1_rsp_ready : m0_rsp_ready);
   assign m0_rsp_valid = w_in_resp & ~r_grant & s_rsp_valid;
   assign m1_rsp_valid = w_in_resp &  r_grant & s_rsp_valid;
   assign m0_rsp_rdata = s_rsp_rdata;
   assign m1_rsp_rdata = s_rsp_rdata;

   assign w_req_fire = s_req_valid & s_req_ready;
   assign w_rsp_fire = s_rsp_valid & s_rsp_ready;
   assign busy       = (r_state != IDLE);
   assign grant      = r_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= 1'b0;
`ifdef MEM_ARB_RR_EN
         r_last  <= 1'b1;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_grant <= w_winner;
                  r_state <= REQ;
               end
            end
            REQ: begin
               if (w_req_fire) r_state <= RESP;
            end
            RESP: begin
               if (w_rsp_fire) begin
                  r_state <= IDLE;
`ifdef MEM_ARB_RR_EN
                  r_last  <= r_grant;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter; expected grant order follows MEM_ARB_RR_EN.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req_valid, m0_req_ready, m0_req_wen, m0_rsp_valid, m0_rsp_ready;
   logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
   logic [3:0]  m0_req_wmask;
   logic        m1_req_valid, m1_req_ready, m1_req_wen, m1_rsp_valid, m1_rsp_ready;
   logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
   logic [3:0]  m1_req_wmask;
   logic        s_req_valid, s_req_ready, s_req_wen, s_rsp_valid, s_rsp_ready;
   logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata;
   logic [3:0]  s_req_wmask;
   logic        busy, grant;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
      .m0_req_wen(m0_req_wen), .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
      .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
      .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
      .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
      .busy(busy), .grant(grant)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge, where new inputs are applied.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_outputs(input string tag);
      chk({tag, " busy"},         {31'd0, busy},         32'd0);
      chk({tag, " s_req_valid"},  {31'd0, s_req_valid},  32'd0);
      chk({tag, " s_rsp_ready"},  {31'd0, s_rsp_ready},  32'd0);
      chk({tag, " m0_req_ready"}, {31'd0, m0_req_ready}, 32'd0);
      chk({tag, " m1_req_ready"}, {31'd0, m1_req_ready}, 32'd0);
      chk({tag, " m0_rsp_valid"}, {31'd0, m0_rsp_valid}, 32'd0);
      chk({tag, " m1_rsp_valid"}, {31'd0, m1_rsp_valid}, 32'd0);
   endtask

   logic exp_g [6];
   int   c0, c1;

   initial begin
      rst = 1'b1;
      m0_req_valid = 0; m0_req_addr = 0; m0_req_wen = 0; m0_req_wdata = 0; m0_req_wmask = 0;
      m0_rsp_ready = 0;
      m1_req_valid = 0; m1_req_addr = 0; m1_req_wen = 0; m1_req_wdata = 0; m1_req_wmask = 0;
      m1_rsp_ready = 0;
      s_req_ready = 0; s_rsp_valid = 0; s_rsp_rdata = 0;
      tick(); tick();
      #1;
      idle_outputs("reset");
      chk("reset grant", {31'd0, grant}, 32'd0);
      rst = 1'b0;

      // m0 read with zero-wait downstream
      tick();
      m0_req_valid = 1; m0_req_addr = 32'h8000_0000; m0_req_wen = 0; m0_rsp_ready = 1;
      s_req_ready = 1;
      #1;
      idle_outputs("rd c0");
      tick();
      #1;
      chk("rd c1 s_req_valid", {31'd0, s_req_valid}, 32'd1);
      chk("rd c1 s_req_addr", s_req_addr, 32'h8000_0000);
      chk("rd c1 m0_req_ready", {31'd0, m0_req_ready}, 32'd1);
      chk("rd c1 grant", {31'd0, grant}, 32'd0);
      chk("rd c1 busy", {31'd0, busy}, 32'd1);
      tick();
      m0_req_valid = 0; s_rsp_valid = 1; s_rsp_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rd c2 m0_rsp_valid", {31'd0, m0_rsp_valid}, 32'd1);
      chk("rd c2 m0_rsp_rdata", m0_rsp_rdata, 32'hDEAD_BEEF);
      chk("rd c2 s_rsp_ready", {31'd0, s_rsp_ready}, 32'd1);
      chk("rd c2 m1_rsp_valid", {31'd0, m1_rsp_valid}, 32'd0);
      tick();
      s_rsp_valid = 0;
      #1;
      chk("rd c3 busy", {31'd0, busy}, 32'd0);

      // Simultaneous requests, three transactions each
`ifdef MEM_ARB_RR_EN
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_g = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
      rst = 1; tick(); rst = 0;
      c0 = 3; c1 = 3;
      for (int k = 0; k < 6; k++) begin
         m0_req_valid = (c0 > 0); m1_req_valid = (c1 > 0);
         s_req_ready = 1; s_rsp_valid = 0; m0_rsp_ready = 1; m1_rsp_ready = 1;
         #1;
         chk($sformatf("tie%0d idle busy", k), {31'd0, busy}, 32'd0);
         tick();
         #1;
         chk($sformatf("tie%0d grant", k), {31'd0, grant}, {31'd0, exp_g[k]});
         chk($sformatf("tie%0d s_req_valid", k), {31'd0, s_req_valid}, 32'd1);
         tick();
         s_rsp_valid = 1; s_rsp_rdata = k;
         #1;
         chk($sformatf("tie%0d rsp_valid", k),
             {31'd0, (exp_g[k] ? m1_rsp_valid : m0_rsp_valid)}, 32'd1);
         chk($sformatf("tie%0d other rsp_valid", k),
             {31'd0, (exp_g[k] ? m0_rsp_valid : m1_rsp_valid)}, 32'd0);
         if (exp_g[k]) c1--; else c0--;
         tick();
      end
      m0_req_valid = 0; m1_req_valid = 0; s_rsp_valid = 0;

      // m1 write stalled 4 cycles downstream
      m1_req_valid = 1; m1_req_addr = 32'h0000_0010; m1_req_wen = 1;
      m1_req_wdata = 32'h1234_5678; m1_req_wmask = 4'hF; s_req_ready = 0;
      tick();
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("wr stall%0d s_req_valid", k), {31'd0, s_req_valid}, 32'd1);
         chk($sformatf("wr stall%0d m1_req_ready", k), {31'd0, m1_req_ready}, 32'd0);
         chk($sformatf("wr stall%0d addr", k), s_req_addr, 32'h0000_0010);
         chk($sformatf("wr stall%0d wdata", k), s_req_wdata, 32'h1234_5678);
         chk($sformatf("wr stall%0d wmask", k), {28'd0, s_req_wmask}, 32'hF);
         chk($sformatf("wr stall%0d wen", k), {31'd0, s_req_wen}, 32'd1);
         tick();
      end
      s_req_ready = 1;
      #1;
      chk("wr fire m1_req_ready", {31'd0, m1_req_ready}, 32'd1);
      tick();
      m1_req_valid = 0; s_req_ready = 0;
      #1;
      chk("wr resp state busy", {31'd0, busy}, 32'd1);
      chk("wr resp s_req_valid", {31'd0, s_req_valid}, 32'd0);
      s_rsp_valid = 1; m1_rsp_ready = 1;
      tick();
      s_rsp_valid = 0;

      // m0 response back-pressured while m1 waits
      m0_req_valid = 1; m0_req_addr = 32'h0000_0100; m0_req_wen = 0; s_req_ready = 1;
      tick();
      tick();
      m0_req_valid = 0; m1_req_valid = 1; m1_req_wen = 0; s_rsp_valid = 1;
      s_rsp_rdata = 32'hCAFE_0001; m0_rsp_ready = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d s_rsp_ready", k), {31'd0, s_rsp_ready}, 32'd0);
         chk($sformatf("bp%0d busy", k), {31'd0, busy}, 32'd1);
         chk($sformatf("bp%0d m0_rsp_valid", k), {31'd0, m0_rsp_valid}, 32'd1);
         chk($sformatf("bp%0d m1_req_ready", k), {31'd0, m1_req_ready}, 32'd0);
         chk($sformatf("bp%0d s_req_valid", k), {31'd0, s_req_valid}, 32'd0);
         tick();
      end
      m0_rsp_ready = 1;
      #1;
      chk("bp fire s_rsp_ready", {31'd0, s_rsp_ready}, 32'd1);
      tick();
      s_rsp_valid = 0;
      #1;
      chk("bp after busy", {31'd0, busy}, 32'd0);
      tick();
      #1;
      chk("m1 grant", {31'd0, grant}, 32'd1);
      chk("m1 s_req_valid", {31'd0, s_req_valid}, 32'd1);
      tick();
      m1_req_valid = 0;

      // Reset while in RESP with a pending downstream response
      s_rsp_valid = 1; m1_rsp_ready = 1; rst = 1;
      #1;
      chk("rst-resp busy before edge", {31'd0, busy}, 32'd1);
      tick();
      rst = 0;
      #1;
      idle_outputs("post-rst");
      chk("post-rst grant", {31'd0, grant}, 32'd0);

      // Stray response while idle
      tick();
      #1;
      idle_outputs("stray");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
